mips_bus_arbiter: RTL and testbench

- Shares the single Avalon-MM master port of the multicycle MIPS CPU between two requesters: instruction fetch (port I) and data load/store (port D).
- Sequences each transfer through the waitrequest handshake, captures readdata, returns a one-cycle ack and raises a wait-timeout error.
- Sits between the CPU datapath/control and the top-level bus pins; the CPU FSM stalls on req & ~ack.

---
 rtl/mips_bus_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 31 +++
 rtl/mips_bus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-MM bus arbiter.
package mips_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam int unsigned WAIT_LIMIT_DEFAULT = 255;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way pick between fetch (I) and data (D) requesters.
module rr_arbiter2
  import mips_bus_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic   elig_i,
  input  logic   elig_d,
  input  grant_t last_grant,
  output logic   grant_valid,
  output grant_t grant
);

  always_comb begin
    grant_valid = elig_i | elig_d;
    grant       = GRANT_I;
    if (elig_d && !elig_i) begin
      grant = GRANT_D;
    end else if (elig_d && elig_i) begin
      // On a tie either data wins outright or the port not served last wins.
      if (DATA_PRIORITY != 0) begin
        grant = GRANT_D;
      end else if (last_grant == GRANT_D) begin
        grant = GRANT_I;
      end else begin
        grant = GRANT_D;
      end
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-MM master between MIPS instruction fetch (I) and load/store (D).
// Every output is registered; each transfer is IDLE -> BUSY -> IDLE with a one-cycle ack.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int DATA_PRIORITY = 1,
  parameter int WAIT_LIMIT    = int'(WAIT_LIMIT_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic                bus_error,
  output logic                err_ack,
  output arb_state_t          dbg_state
);

  // Handshake: a requester raises x_req and holds it (with its address/data)
  // until it sees the one-cycle x_ack; err_ack marks that ack as a timeout abort.
  // On the bus, a transfer completes on the edge where waitrequest is low.

  localparam int BE_W = DATA_W / 8;
  localparam logic [15:0] WAIT_LIMIT_W = 16'(WAIT_LIMIT);

  arb_state_t          state_q, state_d;
  grant_t              last_grant_q, last_grant_d;
  grant_t              owner_q, owner_d;
  logic [15:0]         wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic [BE_W-1:0]     byteenable_q, byteenable_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                err_ack_q, err_ack_d;
  logic                bus_error_q, bus_error_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic   elig_i, elig_d;
  logic   grant_valid;
  grant_t grant;

  // A request still high in its own ack cycle is already served.
  assign elig_i = i_req & ~i_ack_q;
  assign elig_d = d_req & ~d_ack_q;

  rr_arbiter2 #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_pick (
    .elig_i     (elig_i),
    .elig_d     (elig_d),
    .last_grant (last_grant_q),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wait_cnt_d   = wait_cnt_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    err_ack_d    = 1'b0;
    bus_error_d  = bus_error_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant;
          last_grant_d = grant;
          wait_cnt_d   = '0;
          state_d      = BUSY;
          if (grant == GRANT_D) begin
            address_d    = d_addr;
            read_d       = ~d_write;
            write_d      = d_write;
            writedata_d  = d_wdata;
            byteenable_d = d_byteenable;
          end else begin
            address_d    = i_addr;
            read_d       = 1'b1;
            write_d      = 1'b0;
            writedata_d  = '0;
            byteenable_d = '1;
          end
        end
      end
      BUSY: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = IDLE;
          if (owner_q == GRANT_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = readdata;
          end else begin
            d_ack_d = 1'b1;
            if (read_q) begin
              d_rdata_d = readdata;
            end
          end
        end else if (wait_cnt_q + 16'd1 == WAIT_LIMIT_W) begin
          // Slave stalled too long: abort, keep rdata, flag the error for good.
          read_d      = 1'b0;
          write_d     = 1'b0;
          state_d     = IDLE;
          err_ack_d   = 1'b1;
          bus_error_d = 1'b1;
          if (owner_q == GRANT_I) begin
            i_ack_d = 1'b1;
          end else begin
            d_ack_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      owner_q      <= GRANT_I;
      wait_cnt_q   <= '0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      err_ack_q    <= 1'b0;
      bus_error_q  <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wait_cnt_q   <= wait_cnt_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      err_ack_q    <= err_ack_d;
      bus_error_q  <= bus_error_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign i_ack      = i_ack_q;
  assign d_ack      = d_ack_q;
  assign err_ack    = err_ack_q;
  assign bus_error  = bus_error_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: a cycle table plus hand sequences for
// back-to-back loads, wait timeout and asynchronous reset mid-transfer.
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'hBFC0_0000;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = 32'h0000_1000;
  logic [31:0] d_wdata = 32'hDEAD_BEEF;
  logic [3:0]  d_byteenable = 4'b0011;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  // priority instance
  logic        i_ack, d_ack, read, write, bus_error, err_ack;
  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic [3:0]  byteenable;
  arb_state_t  dbg_state;

  // round-robin instance
  logic        r_i_ack, r_d_ack, r_read, r_write, r_bus_error, r_err_ack;
  logic [31:0] r_i_rdata, r_d_rdata, r_address, r_writedata;
  logic [3:0]  r_byteenable;
  arb_state_t  r_dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(1), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ack(d_ack), .d_rdata(d_rdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .bus_error(bus_error), .err_ack(err_ack), .dbg_state(dbg_state)
  );

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(0), .WAIT_LIMIT(4)) dut_rr (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(r_i_ack), .i_rdata(r_i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ack(r_d_ack), .d_rdata(r_d_rdata),
    .address(r_address), .read(r_read), .write(r_write), .writedata(r_writedata),
    .byteenable(r_byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .bus_error(r_bus_error), .err_ack(r_err_ack), .dbg_state(r_dbg_state)
  );

  typedef struct packed {
    logic        i_req, d_req, d_write, wreq;
    logic [31:0] d_addr, rdata;
    logic [4:0]  ctl;   // {read, write, i_ack, d_ack, err_ack}
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata, ird, drd;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic ir, input logic dr, input logic dw, input logic wq,
                              input logic [31:0] da, input logic [31:0] rd, input logic [4:0] c,
                              input logic [31:0] a, input logic [3:0] b, input logic [31:0] w,
                              input logic [31:0] ii, input logic [31:0] dd);
    vec_t v;
    v.i_req = ir; v.d_req = dr; v.d_write = dw; v.wreq = wq;
    v.d_addr = da; v.rdata = rd; v.ctl = c; v.addr = a; v.be = b;
    v.wdata = w; v.ird = ii; v.drd = dd;
    return v;
  endfunction

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads, acks, rd_cycles;
    logic prev_rd, got_ack, saw_err;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {read, write, i_ack, d_ack, err_ack, bus_error, address, writedata, byteenable,
           i_rdata, d_rdata, dbg_state == BUSY},
          '0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Single fetch, store with 3 wait cycles, then a simultaneous I/D request.
    tbl[0]  = mk(1,0,0,0, 32'h1000, 32'h0,        5'b10000, 32'hBFC00000, 4'hF, 32'h0, 32'h0, 32'h0);
    tbl[1]  = mk(1,0,0,0, 32'h1000, 32'h24020005, 5'b00100, 32'hBFC00000, 4'hF, 32'h0, 32'h24020005, 32'h0);
    tbl[2]  = mk(0,0,0,0, 32'h1000, 32'h0,        5'b00000, 32'hBFC00000, 4'hF, 32'h0, 32'h24020005, 32'h0);
    tbl[3]  = mk(0,1,1,1, 32'h1000, 32'h0,        5'b01000, 32'h1000, 4'h3, 32'hDEADBEEF, 32'h24020005, 32'h0);
    tbl[4]  = mk(0,1,1,1, 32'h1000, 32'h0,        5'b01000, 32'h1000, 4'h3, 32'hDEADBEEF, 32'h24020005, 32'h0);
    tbl[5]  = mk(0,1,1,1, 32'h2000, 32'h0,        5'b01000, 32'h1000, 4'h3, 32'hDEADBEEF, 32'h24020005, 32'h0);
    tbl[6]  = mk(0,1,1,1, 32'h1000, 32'h0,        5'b01000, 32'h1000, 4'h3, 32'hDEADBEEF, 32'h24020005, 32'h0);
    tbl[7]  = mk(0,1,1,0, 32'h1000, 32'hCAFEF00D, 5'b00010, 32'h1000, 4'h3, 32'hDEADBEEF, 32'h24020005, 32'h0);
    tbl[8]  = mk(0,0,0,0, 32'h1000, 32'h0,        5'b00000, 32'h1000, 4'h3, 32'hDEADBEEF, 32'h24020005, 32'h0);
    tbl[9]  = mk(1,1,0,0, 32'h1000, 32'h0,        5'b10000, 32'h1000, 4'h3, 32'hDEADBEEF, 32'h24020005, 32'h0);
    tbl[10] = mk(1,1,0,0, 32'h1000, 32'h11111111, 5'b00010, 32'h1000, 4'h3, 32'hDEADBEEF, 32'h24020005, 32'h11111111);
    tbl[11] = mk(1,0,0,0, 32'h1000, 32'h0,        5'b10000, 32'hBFC00000, 4'hF, 32'h0, 32'h24020005, 32'h11111111);
    tbl[12] = mk(1,0,0,0, 32'h1000, 32'h22222222, 5'b00100, 32'hBFC00000, 4'hF, 32'h0, 32'h22222222, 32'h11111111);
    tbl[13] = mk(0,0,0,0, 32'h1000, 32'h0,        5'b00000, 32'hBFC00000, 4'hF, 32'h0, 32'h22222222, 32'h11111111);

    for (int k = 0; k < 14; k++) begin
      i_req = tbl[k].i_req; d_req = tbl[k].d_req; d_write = tbl[k].d_write;
      waitrequest = tbl[k].wreq; d_addr = tbl[k].d_addr; readdata = tbl[k].rdata;
      step();
      check($sformatf("row%0d", k),
            {read, write, i_ack, d_ack, err_ack, address, byteenable, writedata, i_rdata, d_rdata},
            {tbl[k].ctl, tbl[k].addr, tbl[k].be, tbl[k].wdata, tbl[k].ird, tbl[k].drd});
      if (k <= 8) begin
        check($sformatf("rr_row%0d", k),
              {r_read, r_write, r_i_ack, r_d_ack, r_err_ack, r_address, r_byteenable, r_writedata,
               r_i_rdata, r_d_rdata},
              {tbl[k].ctl, tbl[k].addr, tbl[k].be, tbl[k].wdata, tbl[k].ird, tbl[k].drd});
      end
      if (k == 9) check("rr_tie_grants_i", {r_read, r_write, r_address}, {1'b1, 1'b0, 32'hBFC00000});
      if (k == 10) check("rr_tie_i_ack", {r_i_ack, r_d_ack, r_i_rdata}, {1'b1, 1'b0, 32'h11111111});
    end
    check("no_error_yet", {31'b0, bus_error}, 32'd0);

    // Back-to-back loads on port D with d_req held high across acks.
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h100; waitrequest = 1'b0;
    reads = 0; acks = 0; prev_rd = 1'b0;
    for (int cyc = 0; cyc < 40 && acks < 3; cyc++) begin
      readdata = 32'hA000_0000 + 32'(acks);
      step();
      if (read && !prev_rd) reads++;
      prev_rd = read;
      if (d_ack) begin
        check($sformatf("b2b_rdata%0d", acks), d_rdata, 32'hA000_0000 + 32'(acks));
        check($sformatf("b2b_addr%0d", acks), address, 32'h100 + 32'(4 * acks));
        acks++;
        d_addr = d_addr + 32'd4;
      end
    end
    d_req = 1'b0;
    step();
    step();
    check("b2b_acks", 32'(acks), 32'd3);
    check("b2b_reads", 32'(reads + int'(read)), 32'd3);

    // Wait timeout: waitrequest stuck high with WAIT_LIMIT=4.
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h300; waitrequest = 1'b1; readdata = 32'hBAD0BAD0;
    rd_cycles = 0; got_ack = 1'b0; saw_err = 1'b0;
    for (int cyc = 0; cyc < 20 && !got_ack; cyc++) begin
      step();
      if (read) rd_cycles++;
      if (d_ack) begin
        got_ack = 1'b1;
        saw_err = err_ack;
      end
    end
    check("to_read_cycles", 32'(rd_cycles), 32'd4);
    check("to_ack_err", {30'b0, got_ack, saw_err}, {30'b0, 1'b1, 1'b1});
    check("to_flags", {read, bus_error, d_rdata}, {1'b0, 1'b1, 32'hA000_0002});
    d_req = 1'b0; waitrequest = 1'b0;
    step();
    check("to_err_pulse_sticky", {err_ack, bus_error, d_ack}, {1'b0, 1'b1, 1'b0});
    i_addr = 32'hBFC0_0010; i_req = 1'b1; readdata = 32'h0BAD_F00D;
    step();
    check("to_next_grant", {read, address}, {1'b1, 32'hBFC0_0010});
    step();
    check("to_next_ack", {i_ack, err_ack, bus_error, i_rdata}, {1'b1, 1'b0, 1'b1, 32'h0BAD_F00D});
    i_req = 1'b0;
    step();

    // Asynchronous reset in the middle of a stalled load.
    d_req = 1'b1; d_addr = 32'h400; waitrequest = 1'b1;
    step();
    check("rst_busy", {read, dbg_state == BUSY}, 2'b11);
    i_req = 1'b1; i_addr = 32'hBFC0_0020;
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_drop", {read, write, bus_error, dbg_state == BUSY}, 4'b0000);
    step();
    check("rst_no_ack", {i_ack, d_ack, err_ack, read}, 4'b0000);
    @(negedge clk);
    reset = 1'b1; d_req = 1'b0; waitrequest = 1'b0; readdata = 32'h1234_5678;
    step();
    check("rst_regrant", {read, write, address, byteenable}, {1'b1, 1'b0, 32'hBFC0_0020, 4'hF});
    step();
    check("rst_regrant_ack", {i_ack, d_ack, err_ack, i_rdata}, {1'b1, 1'b0, 1'b0, 32'h1234_5678});
    i_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
